// File: rtl/shift_exec_stage.sv
// Two-register shift/rotate execute stage for the 16-bit ALU.
// Right shifts reuse the left barrel shifter via bit reversal.
module shift_exec_stage #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shft,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shft;
    } s1_t;

    function automatic logic [WIDTH-1:0] shl(
        input logic [WIDTH-1:0] x,
        input logic [SHW-1:0]   s
    );
        logic [WIDTH-1:0] t;
        t = x;
        if (s[0]) t = {t[WIDTH-2:0], 1'b0};
        if (s[1]) t = {t[WIDTH-3:0], 2'b0};
        if (s[2]) t = {t[WIDTH-5:0], 4'b0};
        if (s[3]) t = {t[WIDTH-9:0], 8'b0};
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] rev(
        input logic [WIDTH-1:0] x
    );
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = x[WIDTH-1-i];
        end
        return t;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_c_q, out_c_d;
    logic             out_z_q, out_z_d;
    logic             out_n_q, out_n_d;
    logic [15:0]      ops_done_q, ops_done_d;

    logic             s2_free;
    logic             accept;
    logic             advance;
    logic             xfer;

    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        in_ready = !flush && (!s1_valid_q || s2_free);
        accept   = in_valid && in_ready;
        advance  = s1_valid_q && s2_free;
        xfer     = out_valid_q && out_ready;
    end

    logic [SHW-1:0]   sh_m1;
    logic [SHW-1:0]   sh_neg;
    logic [WIDTH-1:0] d_rev;
    logic [WIDTH-1:0] l_sh;
    logic [WIDTH-1:0] l_sh1;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] wrap;
    logic [WIDTH-1:0] keep;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             nz_sh;

    // Carry is the last bit shifted out: one step short of the full shift.
    always_comb begin
        nz_sh  = s1_q.shft != '0;
        sh_m1  = s1_q.shft - 1'b1;
        sh_neg = '0 - s1_q.shft;
        d_rev  = rev(s1_q.data);
        l_sh   = shl(s1_q.data, s1_q.shft);
        l_sh1  = shl(s1_q.data, sh_m1);
        r_sh   = rev(shl(d_rev, s1_q.shft));
        r_sh1  = shl(d_rev, sh_m1);
        wrap   = rev(shl(d_rev, sh_neg));
        keep   = rev(shl('1, s1_q.shft));
        res    = s1_q.data;
        carry  = 1'b0;
        unique case (1'b1)
            (s1_q.op == OP_LSL): begin
                res   = l_sh;
                carry = nz_sh && l_sh1[WIDTH-1];
            end
            (s1_q.op == OP_LSR): begin
                res   = r_sh;
                carry = nz_sh && r_sh1[WIDTH-1];
            end
            (s1_q.op == OP_ASR): begin
                res   = r_sh | (s1_q.data[WIDTH-1] ? ~keep : '0);
                carry = nz_sh && r_sh1[WIDTH-1];
            end
            (s1_q.op == OP_ROL): begin
                res   = l_sh | wrap;
                carry = nz_sh && res[0];
            end
            default: begin
                res   = s1_q.data;
                carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_c_d     = out_c_q;
        out_z_d     = out_z_q;
        out_n_d     = out_n_q;
        ops_done_d  = ops_done_q;

        if (accept) begin
            s1_d.op   = op_e'(in_op);
            s1_d.data = in_data;
            s1_d.shft = in_shft;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        if (advance) begin
            out_data_d = res;
            out_c_d    = carry;
            out_z_d    = res == '0;
            out_n_d    = res[WIDTH-1];
        end

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d = 1'b1;
        end else if (s2_free) begin
            out_valid_d = 1'b0;
        end

        if (xfer && ops_done_q != 16'hFFFF) begin
            ops_done_d = ops_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_c_q     <= 1'b0;
            out_z_q     <= 1'b0;
            out_n_q     <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_c_q     <= out_c_d;
            out_z_q     <= out_z_d;
            out_n_q     <= out_n_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_c     = out_c_q;
    assign out_z     = out_z_q;
    assign out_n     = out_n_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: vector table, scoreboard monitor,
// hand sequences for stall, flush, reset and counter saturation.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [15:0] in_data = 16'd0;
    logic [3:0]  in_shft = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_c;
    logic        out_z;
    logic        out_n;
    logic [15:0] ops_done;

    shift_exec_stage #(.WIDTH(16), .SHW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shft   (in_shft),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_n     (out_n),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        c;
        logic        z;
        logic        n;
    } res_t;

    typedef struct {
        logic [1:0] op;
        logic [15:0] d;
        logic [3:0] s;
        res_t       e;
    } vec_t;

    res_t        q[$];
    res_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;
    vec_t        vt[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(logic [1:0] op, logic [15:0] d,
                                   logic [3:0] s);
        res_t r;
        int k;
        k = int'(s);
        r.c = 1'b0;
        r.d = d;
        case (op)
            2'd0: begin
                r.d = d << k;
                if (k > 0) r.c = d[16-k];
            end
            2'd1: begin
                r.d = d >> k;
                if (k > 0) r.c = d[k-1];
            end
            2'd2: begin
                r.d = $signed(d) >>> k;
                if (k > 0) r.c = d[k-1];
            end
            default: begin
                for (int i = 0; i < k; i++) r.d = {r.d[14:0], r.d[15]};
                if (k > 0) r.c = r.d[0];
            end
        endcase
        r.z = (r.d == 16'd0);
        r.n = r.d[15];
        return r;
    endfunction

    function automatic res_t mk(logic [15:0] d, logic c, logic z, logic n);
        res_t r;
        r.d = d;
        r.c = c;
        r.z = z;
        r.n = n;
        return r;
    endfunction

    // Monitor: pop/compare on each transfer, drop killed entries.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cnt = 16'd0;
        end
        check("ops_done", {16'd0, ops_done}, {16'd0, exp_cnt});
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected none", out_data);
            end else begin
                mon_e = q.pop_front();
                check("out", {13'd0, out_data, out_c, out_z, out_n},
                      {13'd0, mon_e});
            end
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        if (flush) q.delete();
    end

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] s, input res_t e, input bit rnd,
                        output int waits);
        bit done;
        at_pos();
        in_valid = 1'b1;
        in_op = op;
        in_data = d;
        in_shft = s;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        waits = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got %0d waits expected <50", waits);
                    done = 1'b1;
                end else begin
                    at_pos();
                    if (rnd) out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic drain();
        at_pos();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        at_pos();
    endtask

    task automatic setv(input int i, input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] s, input res_t e);
        vt[i].op = op;
        vt[i].d = d;
        vt[i].s = s;
        vt[i].e = e;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [15:0] cnt0;
        logic ov_exp[7];
        logic [1:0] rop;
        logic [15:0] rd;
        logic [3:0] rs;

        setv(0, 2'd0, 16'h8001, 4'd1, mk(16'h0002, 1, 0, 0));
        setv(1, 2'd1, 16'h0003, 4'd1, mk(16'h0001, 1, 0, 0));
        setv(2, 2'd2, 16'h8000, 4'd15, mk(16'hFFFF, 0, 0, 1));
        setv(3, 2'd3, 16'h8001, 4'd4, mk(16'h0018, 0, 0, 0));
        setv(4, 2'd0, 16'hA5A5, 4'd0, mk(16'hA5A5, 0, 0, 1));
        setv(5, 2'd1, 16'hA5A5, 4'd0, mk(16'hA5A5, 0, 0, 1));
        setv(6, 2'd2, 16'hA5A5, 4'd0, mk(16'hA5A5, 0, 0, 1));
        setv(7, 2'd3, 16'hA5A5, 4'd0, mk(16'hA5A5, 0, 0, 1));
        setv(8, 2'd1, 16'h0001, 4'd1, mk(16'h0000, 1, 1, 0));
        setv(9, 2'd0, 16'h0001, 4'd15, mk(16'h8000, 0, 0, 1));
        setv(10, 2'd0, 16'h4000, 4'd2, mk(16'h0000, 1, 1, 0));
        setv(11, 2'd2, 16'h7FFF, 4'd15, mk(16'h0000, 1, 1, 0));
        setv(12, 2'd3, 16'h1234, 4'd8, mk(16'h3412, 0, 0, 0));
        setv(13, 2'd2, 16'hF000, 4'd4, mk(16'hFF00, 0, 0, 1));

        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_flags", {29'd0, out_c, out_z, out_n}, 32'd0);
        check("rst_ops_done", {16'd0, ops_done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) at_pos();
        rst_n = 1'b1;

        out_ready = 1'b1;
        foreach (vt[i]) send(vt[i].op, vt[i].d, vt[i].s, vt[i].e, 1'b0, w);
        drain();

        ov_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 16'(i + 1), 4'd1, mk(16'(2 * (i + 1)), 0, 0, 0), 1'b0, w);
            check("tp_wait", w, 0);
            check("tp_out_valid", {31'd0, out_valid}, {31'd0, ov_exp[i]});
        end
        at_pos();
        in_valid = 1'b0;
        for (int i = 4; i < 7; i++) begin
            @(negedge clk);
            check("tp_out_valid", {31'd0, out_valid}, {31'd0, ov_exp[i]});
        end

        at_pos();
        out_ready = 1'b0;
        send(2'd0, 16'h0001, 4'd1, mk(16'h0002, 0, 0, 0), 1'b0, w);
        check("bp_wait_a", w, 0);
        send(2'd0, 16'h0002, 4'd1, mk(16'h0004, 0, 0, 0), 1'b0, w);
        check("bp_wait_b", w, 0);
        at_pos();
        in_valid = 1'b1;
        in_data = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_stable", {16'd0, out_data}, 32'h0002);
            at_pos();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) q.push_back(mk(16'h0006, 0, 0, 0));
        send(2'd0, 16'h0004, 4'd1, mk(16'h0008, 0, 0, 0), 1'b0, w);
        check("bp_wait_d", w, 0);
        drain();

        out_ready = 1'b0;
        send(2'd0, 16'h0005, 4'd1, mk(16'h000A, 0, 0, 0), 1'b0, w);
        send(2'd0, 16'h0006, 4'd1, mk(16'h000C, 0, 0, 0), 1'b0, w);
        at_pos();
        in_valid = 1'b1;
        in_data = 16'h0007;
        flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        cnt0 = ops_done;
        at_pos();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ops_done", {16'd0, ops_done}, {16'd0, cnt0});
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fl_empty", {31'd0, out_valid}, 32'd0);
        end

        at_pos();
        out_ready = 1'b0;
        send(2'd1, 16'h0080, 4'd3, mk(16'h0010, 0, 0, 0), 1'b0, w);
        send(2'd1, 16'h0100, 4'd3, mk(16'h0020, 0, 0, 0), 1'b0, w);
        at_pos();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        cnt0 = ops_done;
        at_pos();
        flush = 1'b0;
        check("flx_ops_done", {16'd0, ops_done}, {16'd0, cnt0 + 16'd1});
        check("flx_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("flx_empty", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            rop = 2'($urandom_range(0, 3));
            rd = 16'($urandom);
            rs = 4'($urandom_range(0, 15));
            send(rop, rd, rs, model(rop, rd, rs), 1'b1, w);
        end
        drain();

        out_ready = 1'b0;
        send(2'd0, 16'h00FF, 4'd4, mk(16'h0FF0, 0, 0, 0), 1'b0, w);
        send(2'd0, 16'h00FF, 4'd8, mk(16'hFF00, 0, 0, 1), 1'b0, w);
        at_pos();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_out_data", {16'd0, out_data}, 32'd0);
        check("mr_flags", {29'd0, out_c, out_z, out_n}, 32'd0);
        check("mr_ops_done", {16'd0, ops_done}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        at_pos();
        rst_n = 1'b1;
        check("mr_after_valid", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            rop = 2'($urandom_range(0, 3));
            rd = 16'($urandom);
            rs = 4'($urandom_range(0, 15));
            send(rop, rd, rs, model(rop, rd, rs), 1'b0, w);
        end
        drain();
        check("sat_fffe", {16'd0, ops_done}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            send(2'd3, 16'h0F0F, 4'd4, mk(16'hF0F0, 0, 0, 1), 1'b0, w);
        end
        drain();
        check("sat_ffff", {16'd0, ops_done}, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
